pal_cfg_loader: RTL and testbench

//  Byte-to-serial configuration sequencer for the PAL fabric's serial config chain.

---
 rtl/pal_cfg_loader.sv | 173 +++++++++++++++++
 tb/tb_pal_cfg_loader.sv | 319 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pal_cfg_loader.sv
`default_nettype none
// ============================================================================
// Module      : pal_cfg_loader
// Description : Byte-to-serial configuration sequencer for the PAL fabric's
//               serial config chain. Bytes arrive over a valid/ready handshake
//               and are shifted LSB-first into the chain, one bit per clock.
//               Completion, stall timeout and explicit abort are tracked.
// Revision    : 1.0 - initial release
// ============================================================================
module pal_cfg_loader #(
    parameter  int N        = 8,
    parameter  int M        = 4,
    parameter  int P        = 14,
    parameter  int TIMEOUT  = 1024,
    localparam int CFG_BITS = 2*N*P + P*M,
    localparam int CW       = $clog2(CFG_BITS + 1)
) (
    input  logic          clk,
    input  logic          res_n,
    input  logic          start,
    input  logic          abort,
    input  logic [7:0]    in_data,
    input  logic          in_valid,
    output logic          in_ready,
    output logic          cfg_bit,
    output logic          cfg_shift,
    output logic          busy,
    output logic          done,
    output logic          err,
    output logic [CW-1:0] bit_count
);

    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    localparam logic [CW-1:0] C_CFG_BITS = CW'(CFG_BITS);
    localparam logic [TW-1:0] C_TMO_LAST = TW'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_SHIFT = 3'd2,
        S_DONE  = 3'd3,
        S_ERR   = 3'd4
    } state_t;

    state_t        r_state;
    state_t        w_state_next;
    logic [7:0]    r_sr;
    logic [7:0]    w_sr_next;
    logic [3:0]    r_nb;
    logic [3:0]    w_nb_next;
    logic [TW-1:0] r_tmo;
    logic [TW-1:0] w_tmo_next;
    logic [CW-1:0] r_bit_count;
    logic [CW-1:0] w_bc_next;
    logic [CW-1:0] w_bc_inc;
    logic          r_done;
    logic          w_done_next;
    logic          r_err;
    logic          w_err_next;
    logic          r_cfg_shift;
    logic          w_cfg_shift_next;
    logic          r_cfg_bit;
    logic          w_cfg_bit_next;
    logic [31:0]   w_remain;
    logic [3:0]    w_nb_load;

    // Bits still owed to the chain; the last byte may carry fewer than 8.
    assign w_remain  = 32'(CFG_BITS) - 32'(r_bit_count);
    assign w_nb_load = (w_remain >= 32'd8) ? 4'd8 : w_remain[3:0];
    assign w_bc_inc  = r_bit_count + CW'(1);

    // Next-state and datapath decisions; abort overrides everything at the end.
    always_comb begin
        w_state_next = r_state;
        w_sr_next    = r_sr;
        w_nb_next    = r_nb;
        w_tmo_next   = r_tmo;
        w_bc_next    = r_bit_count;
        w_done_next  = r_done;
        w_err_next   = r_err;

        case (r_state)
            S_IDLE, S_DONE, S_ERR: begin
                if (start) begin
                    w_state_next = S_LOAD;
                    w_bc_next    = '0;
                    w_done_next  = 1'b0;
                    w_err_next   = 1'b0;
                    w_tmo_next   = '0;
                end
            end
            S_LOAD: begin
                if (in_valid) begin
                    w_sr_next    = in_data;
                    w_nb_next    = w_nb_load;
                    w_tmo_next   = '0;
                    w_state_next = S_SHIFT;
                end else if (r_tmo == C_TMO_LAST) begin
                    w_state_next = S_ERR;
                    w_err_next   = 1'b1;
                end else begin
                    w_tmo_next   = r_tmo + TW'(1);
                end
            end
            S_SHIFT: begin
                w_sr_next = {1'b0, r_sr[7:1]};
                w_nb_next = r_nb - 4'd1;
                w_bc_next = w_bc_inc;
                if (r_nb == 4'd1) begin
                    if (w_bc_inc == C_CFG_BITS) begin
                        w_state_next = S_DONE;
                        w_done_next  = 1'b1;
                    end else begin
                        w_state_next = S_LOAD;
                    end
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase

        if (abort) begin
            w_state_next = S_IDLE;
            w_sr_next    = r_sr;
            w_nb_next    = r_nb;
            w_tmo_next   = '0;
            w_bc_next    = r_bit_count;
            w_done_next  = 1'b0;
            w_err_next   = 1'b0;
        end

        // Chain strobe and data are registered so they line up with SHIFT.
        w_cfg_shift_next = (w_state_next == S_SHIFT);
        w_cfg_bit_next   = (w_state_next == S_SHIFT) & w_sr_next[0];
    end

    // State and datapath registers; async reset drops the chain strobe at once.
    always_ff @(posedge clk or negedge res_n) begin
        if (!res_n) begin
            r_state     <= S_IDLE;
            r_sr        <= '0;
            r_nb        <= '0;
            r_tmo       <= '0;
            r_bit_count <= '0;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
            r_cfg_shift <= 1'b0;
            r_cfg_bit   <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_sr        <= w_sr_next;
            r_nb        <= w_nb_next;
            r_tmo       <= w_tmo_next;
            r_bit_count <= w_bc_next;
            r_done      <= w_done_next;
            r_err       <= w_err_next;
            r_cfg_shift <= w_cfg_shift_next;
            r_cfg_bit   <= w_cfg_bit_next;
        end
    end

    assign in_ready  = (r_state == S_LOAD);
    assign busy      = (r_state == S_LOAD) || (r_state == S_SHIFT);
    assign cfg_shift = r_cfg_shift;
    assign cfg_bit   = r_cfg_bit;
    assign done      = r_done;
    assign err       = r_err;
    assign bit_count = r_bit_count;

endmodule
`default_nettype wire

// File: tb/tb_pal_cfg_loader.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_pal_cfg_loader
// Description : Self-checking bench for pal_cfg_loader. A full-size loader
//               (280 bits) and a small loader (15 bits, partial last byte)
//               share the stimulus; one is observed at a time.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pal_cfg_loader;

    localparam int CFG_B = 280;
    localparam int CFG_S = 15;
    localparam int TMO   = 16;

    logic       clk      = 1'b0;
    logic       res_n    = 1'b0;
    logic       start    = 1'b0;
    logic       abort    = 1'b0;
    logic       in_valid = 1'b0;
    logic [7:0] in_data  = 8'h00;

    logic       rdy_b, bit_b, sh_b, busy_b, done_b, err_b;
    logic [8:0] bc_b;
    logic       rdy_s, bit_s, sh_s, busy_s, done_s, err_s;
    logic [3:0] bc_s;

    pal_cfg_loader #(.TIMEOUT(TMO)) u_big (
        .clk(clk), .res_n(res_n), .start(start), .abort(abort),
        .in_data(in_data), .in_valid(in_valid), .in_ready(rdy_b),
        .cfg_bit(bit_b), .cfg_shift(sh_b), .busy(busy_b), .done(done_b),
        .err(err_b), .bit_count(bc_b)
    );

    pal_cfg_loader #(.N(2), .M(1), .P(3), .TIMEOUT(TMO)) u_small (
        .clk(clk), .res_n(res_n), .start(start), .abort(abort),
        .in_data(in_data), .in_valid(in_valid), .in_ready(rdy_s),
        .cfg_bit(bit_s), .cfg_shift(sh_s), .busy(busy_s), .done(done_s),
        .err(err_s), .bit_count(bc_s)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Observed loader selection: 0 = full size, 1 = small.
    logic        sel = 1'b0;
    logic        o_rdy, o_bit, o_shift, o_busy, o_done, o_err;
    logic [15:0] o_bc;
    int          cfg_cur;
    assign o_rdy   = sel ? rdy_s  : rdy_b;
    assign o_bit   = sel ? bit_s  : bit_b;
    assign o_shift = sel ? sh_s   : sh_b;
    assign o_busy  = sel ? busy_s : busy_b;
    assign o_done  = sel ? done_s : done_b;
    assign o_err   = sel ? err_s  : err_b;
    assign o_bc    = sel ? 16'(bc_s) : 16'(bc_b);
    assign cfg_cur = sel ? CFG_S : CFG_B;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Bits seen on the chain and lengths of each uninterrupted shift burst.
    logic got[$];
    int   runs[$];
    int   run = 0;

    always @(negedge clk) begin
        if (!res_n) begin
            run = 0;
        end else begin
            if (o_shift === 1'b1) begin
                got.push_back(o_bit);
                run++;
                chk("ready_low_in_shift", o_rdy, 0);
            end else if (run != 0) begin
                runs.push_back(run);
                run = 0;
            end
            chk("bc_bound", (o_bc <= 16'(cfg_cur)) ? 1 : 0, 1);
        end
    end

    // Waits (bounded) until the loader asks for data again or finishes.
    task automatic wait_ready_or_end();
        int w;
        w = 0;
        while (o_rdy !== 1'b1 && o_done !== 1'b1 && o_err !== 1'b1 && w < 40) begin
            @(negedge clk);
            start = 1'b0;
            w++;
        end
        start = 1'b0;
        chk("wait_bound", (w < 40) ? 1 : 0, 1);
    endtask

    // One complete load; expectations come from the byte list and timing rules.
    task automatic run_load(input logic s, input int max_gap, input logic use_fixed,
                            input logic [7:0] fixed_b, input logic noise);
        int         cfg, nbytes, nb, gap, exp_cyc, mism;
        logic [7:0] b;
        logic       exp_bits[$];
        int         exp_runs[$];
        sel    = s;
        cfg    = s ? CFG_S : CFG_B;
        nbytes = (cfg + 7) / 8;
        got.delete();
        runs.delete();
        start   = 1'b1;
        exp_cyc = cyc + 1;
        @(negedge clk);
        start = 1'b0;
        chk("load_bc_clear", o_bc, 0);
        chk("load_ready", o_rdy, 1);
        chk("load_busy", o_busy, 1);
        chk("load_done_clear", o_done, 0);
        for (int i = 0; i < nbytes; i++) begin
            gap = (max_gap > 0) ? int'($urandom_range(0, max_gap)) : 0;
            b   = use_fixed ? fixed_b : 8'($urandom);
            nb  = (cfg - 8*i < 8) ? (cfg - 8*i) : 8;
            for (int k = 0; k < nb; k++) exp_bits.push_back(b[k]);
            exp_runs.push_back(nb);
            exp_cyc += gap + 1 + nb;
            repeat (gap) @(negedge clk);
            chk("ready_before_xfer", o_rdy, 1);
            in_valid = 1'b1;
            in_data  = b;
            @(negedge clk);
            in_valid = 1'b0;
            in_data  = 8'($urandom);
            if (noise) start = 1'b1;
            wait_ready_or_end();
            chk("byte_end_cycle", cyc, exp_cyc);
        end
        chk("done_set", o_done, 1);
        chk("done_err_low", o_err, 0);
        chk("done_busy_low", o_busy, 0);
        chk("done_bit_count", o_bc, cfg);
        // Bytes offered after completion must not be consumed.
        in_valid = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("done_no_ready", o_rdy, 0);
            chk("done_no_shift", o_shift, 0);
            chk("done_sticky", o_done, 1);
        end
        in_valid = 1'b0;
        chk("stream_len", got.size(), exp_bits.size());
        mism = 0;
        for (int k = 0; k < exp_bits.size() && k < got.size(); k++)
            if (got[k] !== exp_bits[k]) mism++;
        chk("stream_bits", mism, 0);
        chk("burst_count", runs.size(), exp_runs.size());
        mism = 0;
        for (int k = 0; k < exp_runs.size() && k < runs.size(); k++)
            if (runs[k] != exp_runs[k]) mism++;
        chk("burst_lengths", mism, 0);
    endtask

    // Send n bytes back to back, then stall until the timeout fires.
    task automatic run_timeout(input int n);
        int l, w;
        sel   = 1'b0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < n; i++) begin
            in_valid = 1'b1;
            in_data  = 8'($urandom);
            @(negedge clk);
            in_valid = 1'b0;
            wait_ready_or_end();
        end
        chk("tmo_reload", o_rdy, 1);
        l = cyc;
        w = 0;
        while (o_err !== 1'b1 && w < 40) begin
            @(negedge clk);
            w++;
        end
        chk("tmo_err_cycle", cyc, l + TMO);
        chk("tmo_bit_count", o_bc, 8*n);
        chk("tmo_done_low", o_done, 0);
        chk("tmo_busy_low", o_busy, 0);
        in_valid = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("tmo_no_shift", o_shift, 0);
            chk("tmo_err_sticky", o_err, 1);
        end
        in_valid = 1'b0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("tmo_restart_err", o_err, 0);
        chk("tmo_restart_bc", o_bc, 0);
        chk("tmo_restart_ready", o_rdy, 1);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("tmo_abort_idle", o_busy, 0);
    endtask

    // Abort on the k-th shift of the second byte.
    task automatic run_abort(input int k);
        sel   = 1'b0;
        start = 1'b1;
        @(negedge clk);
        start    = 1'b0;
        in_valid = 1'b1;
        in_data  = 8'($urandom);
        @(negedge clk);
        in_valid = 1'b0;
        wait_ready_or_end();
        in_valid = 1'b1;
        in_data  = 8'($urandom);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (k - 1) @(negedge clk);
        chk("abort_in_shift", o_shift, 1);
        abort = 1'b1;
        start = 1'($urandom_range(0, 1));
        @(negedge clk);
        abort = 1'b0;
        start = 1'b0;
        chk("abort_bit_count", o_bc, 8 + k - 1);
        chk("abort_busy", o_busy, 0);
        chk("abort_shift", o_shift, 0);
        chk("abort_ready", o_rdy, 0);
        chk("abort_done", o_done, 0);
        @(negedge clk);
        chk("abort_stays_idle", o_busy, 0);
        chk("abort_bc_held", o_bc, 8 + k - 1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state.
        @(negedge clk);
        chk("rst_ready", o_rdy, 0);
        chk("rst_shift", o_shift, 0);
        chk("rst_bit", o_bit, 0);
        chk("rst_busy", o_busy, 0);
        chk("rst_done", o_done, 0);
        chk("rst_err", o_err, 0);
        chk("rst_bc", o_bc, 0);
        res_n = 1'b1;
        @(negedge clk);
        chk("idle_ready", o_rdy, 0);

        // Full load of 0xA5, then a reload with random gaps, data and stray starts.
        run_load(1'b0, 0, 1'b1, 8'hA5, 1'b0);
        run_load(1'b0, 5, 1'b0, 8'h00, 1'b1);

        // Abort and start together in DONE: abort wins, count held.
        abort = 1'b1;
        start = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        start = 1'b0;
        chk("abort_start_busy", o_busy, 0);
        chk("abort_start_done", o_done, 0);
        chk("abort_start_bc", o_bc, CFG_B);

        // Host stalls.
        run_timeout(3);
        run_timeout(int'($urandom_range(1, 4)));

        // Aborts mid-shift, then a fresh load must run to completion.
        run_abort(4);
        run_abort(int'($urandom_range(1, 8)));
        run_load(1'b0, 2, 1'b0, 8'h00, 1'b0);

        // Asynchronous reset in the middle of a shift burst.
        start = 1'b1;
        @(negedge clk);
        start    = 1'b0;
        in_valid = 1'b1;
        in_data  = 8'hFF;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (int'($urandom_range(0, 6))) @(negedge clk);
        chk("rst_mid_shifting", o_shift, 1);
        #2 res_n = 1'b0;
        #1;
        chk("arst_shift", o_shift, 0);
        chk("arst_bit", o_bit, 0);
        chk("arst_busy", o_busy, 0);
        chk("arst_bc", o_bc, 0);
        @(negedge clk);
        res_n = 1'b1;
        @(negedge clk);
        chk("arst_release_ready", o_rdy, 0);
        chk("arst_release_busy", o_busy, 0);

        // Partial last byte on the 15-bit chain.
        run_load(1'b1, 0, 1'b1, 8'hFF, 1'b0);
        run_load(1'b1, 3, 1'b0, 8'h00, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
